// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core widths, reset PC, fetch state encoding and opcode constants
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, IDLE_HALT} fetch_state_t;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;
    function automatic logic [6:0] opcode_of(input logic [XLEN-1:0] word);
        return word[6:0];
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response, decode handoff and redirect signals
interface fetch_unit_if #(parameter int XLEN = 32);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rdata;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, pc, pc_plus4,
        input  imem_req_ready, imem_rsp_valid, imem_rdata, instr_ready, redirect, redirect_target
    );
    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, pc, pc_plus4,
        output imem_req_ready, imem_rsp_valid, imem_rdata, instr_ready, redirect, redirect_target
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: fetch PC register with +4 advance and redirect mux (redirect wins)
module fetch_pc_reg #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] fetch_pc
);
    always_ff @(posedge clk)
        fetch_pc <= reset ? RESET_PC : redirect ? target : advance ? fetch_pc + XLEN'(4) : fetch_pc;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch FSM and one-entry instruction buffer; FETCH_ALIGN_CHECK_EN adds fetch_misalign halt
module fetch_unit #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic clk,
    input  logic reset,
    fetch_unit_if.master bus
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic fetch_misalign
`endif
);
    import riscv_pkg::*;
    fetch_state_t    state;
    logic            drop;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] target;
`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = bus.redirect && bus.redirect_target[1:0] != 2'b00;
    assign target = bus.redirect_target;
`else
    assign target = bus.redirect_target & ~XLEN'(3);
`endif
    assign bus.imem_addr = fetch_pc;
    fetch_pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
        .clk(clk),
        .reset(reset),
        .advance(state == FULL && bus.instr_ready),
        .redirect(bus.redirect),
        .target(target),
        .fetch_pc(fetch_pc)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            drop               <= 1'b0;
            bus.imem_req_valid <= 1'b0;
            bus.instr_valid    <= 1'b0;
            bus.instr          <= '0;
            bus.pc             <= RESET_PC;
            bus.pc_plus4       <= RESET_PC + XLEN'(4);
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_misalign     <= 1'b0;
        end else if (state == IDLE_HALT || misaligned) begin
            state              <= IDLE_HALT;
            fetch_misalign     <= 1'b1;
            bus.imem_req_valid <= 1'b0;
            bus.instr_valid    <= 1'b0;
`endif
        end else if (bus.redirect) begin
            bus.instr_valid <= 1'b0;
            // An accepted-but-unanswered request is now wrong-path; a response arriving this cycle retires it
            if ((state == REQ && bus.imem_req_ready) || (state == WAIT && !bus.imem_rsp_valid)) begin
                state              <= WAIT;
                drop               <= 1'b1;
                bus.imem_req_valid <= 1'b0;
            end else begin
                state              <= REQ;
                drop               <= 1'b0;
                bus.imem_req_valid <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    state              <= REQ;
                    bus.imem_req_valid <= 1'b1;
                end
                REQ: if (bus.imem_req_ready) begin
                    state              <= WAIT;
                    bus.imem_req_valid <= 1'b0;
                end
                WAIT: if (bus.imem_rsp_valid) begin
                    if (drop) begin
                        drop               <= 1'b0;
                        state              <= REQ;
                        bus.imem_req_valid <= 1'b1;
                    end else begin
                        state           <= FULL;
                        bus.instr       <= bus.imem_rdata;
                        bus.pc          <= fetch_pc;
                        bus.pc_plus4    <= fetch_pc + XLEN'(4);
                        bus.instr_valid <= 1'b1;
                    end
                end
                FULL: if (bus.instr_ready) begin
                    state              <= REQ;
                    bus.instr_valid    <= 1'b0;
                    bus.imem_req_valid <= 1'b1;
                end
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch timing, stalls, redirects, wrap and reset
module tb_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    int total = 0;
    int bad = 0;
    fetch_unit_if #(.XLEN(32)) bus();
`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign;
`endif
    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misalign(misalign)
`endif
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    initial begin
        reset = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rdata = '0;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = '0;
        step();
        step();
        check("rst_req_valid", 32'(bus.imem_req_valid), 0);
        check("rst_instr_valid", 32'(bus.instr_valid), 0);
        check("rst_instr", bus.instr, 0);
        check("rst_pc", bus.pc, 0);
        check("rst_pc_plus4", bus.pc_plus4, 4);
        check("rst_addr", bus.imem_addr, 0);
        reset = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready = 1'b1;
        bus.imem_rdata = 32'h0050_0093;
        step();
        check("req0_valid", 32'(bus.imem_req_valid), 1);
        check("req0_addr", bus.imem_addr, 0);
        step();
        check("wait0_valid", 32'(bus.imem_req_valid), 0);
        bus.imem_rsp_valid = 1'b1;
        step();
        check("full0_valid", 32'(bus.instr_valid), 1);
        check("full0_instr", bus.instr, 32'h0050_0093);
        check("full0_pc", bus.pc, 0);
        check("full0_pc4", bus.pc_plus4, 4);
        bus.imem_rsp_valid = 1'b0;
        step();
        check("req1_valid", 32'(bus.imem_req_valid), 1);
        check("req1_addr", bus.imem_addr, 4);
        check("req1_ivalid", 32'(bus.instr_valid), 0);
        step();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata = 32'h00a0_0113;
        step();
        check("full1_pc", bus.pc, 4);
        check("full1_instr", bus.instr, 32'h00a0_0113);
        bus.instr_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rdata = 32'hffff_ffff;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 32'(bus.instr_valid), 1);
            check("stall_pc", bus.pc, 4);
            check("stall_instr", bus.instr, 32'h00a0_0113);
            check("stall_noreq", 32'(bus.imem_req_valid), 0);
        end
        bus.instr_ready = 1'b1;
        step();
        check("req2_valid", 32'(bus.imem_req_valid), 1);
        check("req2_addr", bus.imem_addr, 8);
        step();
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h100;
        step();
        bus.redirect = 1'b0;
        check("wredir_noreq", 32'(bus.imem_req_valid), 0);
        step();
        step();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata = 32'hdead_beef;
        step();
        check("drop_ivalid", 32'(bus.instr_valid), 0);
        check("drop_req", 32'(bus.imem_req_valid), 1);
        check("drop_addr", bus.imem_addr, 32'h100);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_req_ready = 1'b0;
        step();
        check("hold_addr", bus.imem_addr, 32'h100);
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h40;
        step();
        bus.redirect = 1'b0;
        check("rredir_req", 32'(bus.imem_req_valid), 1);
        check("rredir_addr", bus.imem_addr, 32'h40);
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata = 32'h1111_1111;
        step();
        check("r40_valid", 32'(bus.instr_valid), 1);
        check("r40_pc", bus.pc, 32'h40);
        check("r40_pc4", bus.pc_plus4, 32'h44);
        check("r40_instr", bus.instr, 32'h1111_1111);
        bus.imem_rsp_valid = 1'b0;
        step();
        check("r44_addr", bus.imem_addr, 32'h44);
        step();
        reset = 1'b1;
        step();
        check("mrst_req", 32'(bus.imem_req_valid), 0);
        check("mrst_ivalid", 32'(bus.instr_valid), 0);
        check("mrst_pc", bus.pc, 0);
        reset = 1'b0;
        step();
        check("mrst_req2", 32'(bus.imem_req_valid), 1);
        check("mrst_addr", bus.imem_addr, 0);
        bus.redirect = 1'b1;
        bus.redirect_target = 32'hffff_fffc;
        step();
        bus.redirect = 1'b0;
        check("hsredir_noreq", 32'(bus.imem_req_valid), 0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata = 32'h3333_3333;
        step();
        check("hsdrop_ivalid", 32'(bus.instr_valid), 0);
        check("hsdrop_addr", bus.imem_addr, 32'hffff_fffc);
        bus.imem_rsp_valid = 1'b0;
        step();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rdata = 32'h2222_2222;
        step();
        check("wrap_pc", bus.pc, 32'hffff_fffc);
        check("wrap_pc4", bus.pc_plus4, 0);
        check("wrap_instr", bus.instr, 32'h2222_2222);
        bus.imem_rsp_valid = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h200;
        step();
        bus.redirect = 1'b0;
        check("fredir_ivalid", 32'(bus.instr_valid), 0);
        check("fredir_addr", bus.imem_addr, 32'h200);
        check("fredir_req", 32'(bus.imem_req_valid), 1);
        bus.imem_req_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_target = 32'h102;
        step();
        bus.redirect = 1'b0;
        bus.imem_req_ready = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_flag", 32'(misalign), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mis_noreq", 32'(bus.imem_req_valid), 0);
            check("mis_sticky", 32'(misalign), 1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mis_rst", 32'(misalign), 0);
`else
        check("mis_addr", bus.imem_addr, 32'h100);
        check("mis_req", 32'(bus.imem_req_valid), 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the main decoder.
- Owns the PC register and issues word requests to a variable-latency instruction memory over a valid/ready handshake.
- Holds the returned word in a one-entry instruction buffer and presents it to decode (opcode bits [6:0] feed the main decoder) with a valid/ready handshake.
- Accepts taken-branch/jump redirects from execute and discards in-flight wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address
XLEN, 32, address/instruction width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_addr  output  XLEN  word address of request
imem_rsp_valid  input  1  read data valid (one per accepted request, in order, ≥1 cycle after accept)
imem_rdata  input  XLEN  instruction word
instr_valid  output  1  instruction buffer holds a valid instruction
instr_ready  input  1  decode consumes instruction this cycle
instr  output  XLEN  buffered instruction
pc  output  XLEN  address of buffered instruction
pc_plus4  output  XLEN  pc + 4 (for jal link / result_src=10)
redirect  input  1  taken branch or jump resolved
redirect_target  input  XLEN  new fetch address

Behaviour:
- Reset (sync): state=IDLE, fetch_pc=RESET_PC, drop=0, imem_req_valid=0, imem_addr=RESET_PC, instr_valid=0, instr=0, pc=RESET_PC, pc_plus4=RESET_PC+4.
- States:
  - IDLE: unconditionally → REQ next cycle.
  - REQ: imem_req_valid=1, imem_addr=fetch_pc; on imem_req_ready → WAIT.
  - WAIT: on imem_rsp_valid, if drop=0: instr<=imem_rdata, pc<=fetch_pc, pc_plus4<=fetch_pc+4, instr_valid<=1 → FULL. If drop=1: clear drop, discard data → REQ.
  - FULL: instr_valid=1; on instr_ready: instr_valid<=0, fetch_pc<=fetch_pc+4 → REQ.
- Zero-wait memory (ready=1, rsp one cycle after accept): request at cycle N, instr_valid at N+2, throughput 1 instruction per 3 cycles plus decode stall cycles.
- Outputs instr/pc/pc_plus4 are stable while instr_valid=1 and instr_ready=0.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Redirect has priority over all other events in the same cycle:
  - fetch_pc<=redirect_target; instr_valid<=0.
  - From REQ without handshake: stay in REQ; imem_addr changes next cycle. The imem protocol permits changing an unaccepted request.
  - From REQ with handshake in the same cycle, or from WAIT: drop<=1, next state WAIT. If rsp arrives in the same cycle as a redirect in WAIT, discard it → REQ, with drop left 0.
  - From FULL (with or without instr_ready): → REQ. No +4 increment.
  - From IDLE: → REQ at target.
- Reset mid-operation (any state, including WAIT with a response outstanding): returns to IDLE.
  - The memory must not return a response for a pre-reset request; this is a system requirement, not checked here.
- imem_rsp_valid outside WAIT is ignored.

Optional Feature:
Macro FETCH_ALIGN_CHECK_EN.
- Defined: adds output port fetch_misalign (1 bit, reset 0).
  - A redirect with redirect_target[1:0]≠0 sets fetch_misalign (sticky until reset) and forces state IDLE_HALT.
  - IDLE_HALT: no requests, instr_valid=0, left only by reset.
- Undefined: no port; target[1:0] is ignored, and imem_addr is driven with bits [1:0] forced to 00.

Decomposition:
- Shared package riscv_pkg: XLEN, RESET_PC default, fetch state enum (IDLE, REQ, WAIT, FULL, IDLE_HALT), OPCODE_* constants shared with the main decoder.
- One natural sub-module: fetch_pc_reg, holding the PC register, +4 adder and redirect mux (inputs: advance, redirect, target; output: fetch_pc).
- FSM and buffer stay in fetch_unit.

Test Plan:
- Reset, ready=1, 1-cycle rsp, instr_ready=1, rdata=0x00500093 → imem_addr 0x0,0x4,0x8 on successive REQ cycles; instr_valid 2 cycles after each accept; pc=0x0, pc_plus4=0x4 with first instr.
- Decode stall: instr_ready=0 for 5 cycles in FULL → instr/pc held constant, no imem_req_valid; release → next request addr = pc+4.
- Redirect in WAIT to 0x100, old rsp (0xDEADBEEF) 3 cycles later → data discarded, instr_valid never shows it, next request addr 0x100.
- Redirect in REQ with imem_req_ready=0 to 0x40 → imem_addr=0x40 next cycle; no drop; first delivered pc=0x40.
- Reset asserted in WAIT → next cycle imem_req_valid=0, instr_valid=0, pc=RESET_PC; REQ with addr RESET_PC the cycle after.
- FETCH_ALIGN_CHECK_EN: redirect to 0x102 → fetch_misalign=1 next cycle, no further requests until reset; without the macro, imem_addr=0x100.
